// File: rtl/fifo_pkg.sv
//------------------------------------------------------------------------------
// Module      : fifo_pkg
// Description : Shared defaults and helper for the fifo_ctrl slice.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  localparam int DEFAULT_DWIDTH = 8;
  localparam int DEFAULT_AWIDTH = 4;

  function automatic int usedw_width(input int awidth);
    return awidth + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ctrl_ram.sv
//------------------------------------------------------------------------------
// Module      : ram
// Description : Simple dual-port RAM, registered read, no reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AWIDTH-1:0] rd_addr_i,
  output logic [DWIDTH-1:0] rd_data_o
);

  logic [DWIDTH-1:0] r_mem [2**AWIDTH];
  logic [DWIDTH-1:0] r_rd_data;

  // Read data holds between enabled reads; callers rely on that.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) r_mem[wr_addr_i] <= wr_data_i;
    if (rd_en_i) r_rd_data <= r_mem[rd_addr_i];
  end

  assign rd_data_o = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/fifo_ctrl.sv
//------------------------------------------------------------------------------
// Module      : fifo_ctrl
// Description : Single-clock SCFIFO-style controller around a registered-read
//               RAM. Define FIFO_SHOWAHEAD_EN for first-word fall-through.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DWIDTH       = DEFAULT_DWIDTH,
  parameter int AWIDTH       = DEFAULT_AWIDTH,
  parameter int ALMOST_FULL  = 12,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [DWIDTH-1:0]               data_i,
  input  logic                            wrreq_i,
  input  logic                            rdreq_i,
  output logic [DWIDTH-1:0]               q_o,
  output logic                            empty_o,
  output logic                            full_o,
  output logic [usedw_width(AWIDTH)-1:0]  usedw_o,
  output logic                            almost_full_o,
  output logic                            almost_empty_o
);

  localparam int             UW      = usedw_width(AWIDTH);
  localparam logic [UW-1:0]  c_depth = UW'(2**AWIDTH);
  localparam logic [UW-1:0]  c_afull = UW'(ALMOST_FULL);
  localparam logic [UW-1:0]  c_aempt = UW'(ALMOST_EMPTY);

  logic [AWIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [UW-1:0]     r_usedw, w_usedw_nxt;
  logic              r_empty, r_full, r_afull, r_aempty;
  logic              w_empty_nxt;
  logic              w_wr_acc, w_rd_acc, w_ram_rd_en;
  logic [DWIDTH-1:0] w_ram_q;

  assign w_wr_acc = wrreq_i & ~r_full;
  assign w_rd_acc = rdreq_i & ~r_empty;

  always_comb begin
    w_usedw_nxt = r_usedw;
    if (w_wr_acc && !w_rd_acc)      w_usedw_nxt = r_usedw + 1'b1;
    else if (w_rd_acc && !w_wr_acc) w_usedw_nxt = r_usedw - 1'b1;
  end

`ifdef FIFO_SHOWAHEAD_EN
  // Words sitting in RAM that have not yet been moved into the head register.
  logic [UW-1:0] r_ram_cnt, w_ram_cnt_nxt;
  logic          w_fetch;

  assign w_fetch     = (r_ram_cnt != '0) & (r_empty | w_rd_acc);
  assign w_ram_rd_en = w_fetch;
  assign w_empty_nxt = ~w_fetch & (r_empty | w_rd_acc);

  always_comb begin
    w_ram_cnt_nxt = r_ram_cnt;
    if (w_wr_acc && !w_fetch)      w_ram_cnt_nxt = r_ram_cnt + 1'b1;
    else if (w_fetch && !w_wr_acc) w_ram_cnt_nxt = r_ram_cnt - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ram_cnt <= '0;
    else         r_ram_cnt <= w_ram_cnt_nxt;
  end

  assign q_o = r_empty ? '0 : w_ram_q;
`else
  logic r_q_vld;

  assign w_ram_rd_en = w_rd_acc;
  assign w_empty_nxt = (w_usedw_nxt == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       r_q_vld <= 1'b0;
    else if (w_rd_acc) r_q_vld <= 1'b1;
  end

  // The RAM output is undefined until the first read after reset.
  assign q_o = r_q_vld ? w_ram_q : '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usedw  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= (ALMOST_FULL == 0);
    end else begin
      if (w_wr_acc)    r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_ram_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_usedw  <= w_usedw_nxt;
      r_empty  <= w_empty_nxt;
      r_full   <= (w_usedw_nxt == c_depth);
      r_afull  <= (w_usedw_nxt >= c_afull);
      r_aempty <= (w_usedw_nxt < c_aempt);
    end
  end

  ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (w_wr_acc),
    .wr_addr_i (r_wr_ptr),
    .wr_data_i (data_i),
    .rd_en_i   (w_ram_rd_en),
    .rd_addr_i (r_rd_ptr),
    .rd_data_o (w_ram_q)
  );

  assign empty_o        = r_empty;
  assign full_o         = r_full;
  assign usedw_o        = r_usedw;
  assign almost_full_o  = r_afull;
  assign almost_empty_o = r_aempty;

endmodule

`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_fifo_ctrl
// Description : Scoreboard bench for fifo_ctrl against a queue-based FIFO model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_ctrl;
  import fifo_pkg::*;

  localparam int DW    = DEFAULT_DWIDTH;
  localparam int AW    = 2;
  localparam int DEPTH = 2**AW;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data = '0;
  logic          wrreq = 1'b0;
  logic          rdreq = 1'b0;
  logic [DW-1:0] q;
  logic          empty, full, afull, aempty;
  logic [AW:0]   usedw;

  fifo_ctrl #(
    .DWIDTH       (DW),
    .AWIDTH       (AW),
    .ALMOST_FULL  (AF),
    .ALMOST_EMPTY (AE)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .data_i         (data),
    .wrreq_i        (wrreq),
    .rdreq_i        (rdreq),
    .q_o            (q),
    .empty_o        (empty),
    .full_o         (full),
    .usedw_o        (usedw),
    .almost_full_o  (afull),
    .almost_empty_o (aempty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int usedw;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] m_fifo[$];
  int            m_last;
  int            compared = 0;
  int            mismatched = 0;
  exp_t          e;

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_status(input string tag, input int u, input int qv);
    check({tag, " q"},      int'(q), qv);
    check({tag, " usedw"},  int'(usedw), u);
    check({tag, " empty"},  int'(empty), int'(u == 0));
    check({tag, " full"},   int'(full), int'(u == DEPTH));
    check({tag, " afull"},  int'(afull), int'(u >= AF));
    check({tag, " aempty"}, int'(aempty), int'(u < AE));
  endtask

  // Model: a plain queue; reads see the fill level before this cycle's write.
  task automatic cycle(input logic wr, input logic rd, input logic [DW-1:0] d);
    bit wa, ra;
    @(negedge clk);
    wrreq = wr;
    rdreq = rd;
    data  = d;
    wa = wr && (m_fifo.size() < DEPTH);
    ra = rd && (m_fifo.size() > 0);
    if (ra) m_last = int'(m_fifo.pop_front());
    if (wa) m_fifo.push_back(d);
    exp_q.push_back('{q: m_last, usedw: m_fifo.size()});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wrreq = 1'b0;
    rdreq = 1'b0;
    #1;
    check_status("reset", 0, 0);
    m_fifo.delete();
    m_last = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one expected entry per issued cycle, compared after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_status("cycle", e.usedw, e.q);
      end
    end
  end

  initial begin
    m_last = 0;
`ifdef FIFO_SHOWAHEAD_EN
    do_reset();
    @(negedge clk);
    wrreq = 1'b1;
    data  = 8'h77;
    @(negedge clk);
    wrreq = 1'b0;
    check("sa empty after 1", int'(empty), 1);
    @(negedge clk);
    check("sa empty after 2", int'(empty), 0);
    check("sa q after 2", int'(q), 'h77);
    check("sa usedw", int'(usedw), 1);
    rdreq = 1'b1;
    @(negedge clk);
    rdreq = 1'b0;
    check("sa empty after pop", int'(empty), 1);
    check("sa usedw after pop", int'(usedw), 0);
`else
    do_reset();
    // ordering
    cycle(1, 0, 8'h11); cycle(1, 0, 8'h22); cycle(1, 0, 8'h33);
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'h00);
    // overflow
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'hA0 + 8'(i));
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'h00);
    // underflow after reset
    do_reset();
    cycle(0, 1, 8'h00); cycle(0, 1, 8'h00);
    cycle(1, 0, 8'h5A); cycle(0, 1, 8'h00); cycle(0, 0, 8'h00);
    // simultaneous requests at full and at empty
    for (int i = 0; i < 4; i++) cycle(1, 0, 8'hB0 + 8'(i));
    cycle(1, 1, 8'hEE);
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'h00);
    cycle(1, 1, 8'hC3);
    cycle(0, 1, 8'h00);
    // stream across the pointer wrap, read one cycle behind
    for (int i = 0; i <= 10; i++) cycle(i < 10, i >= 1, 8'h60 + 8'(i));
    // climb to the almost-full threshold and back
    for (int i = 0; i < 4; i++) cycle(1, 0, 8'h90 + 8'(i));
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'h00);
    // reset mid-stream with two words stored
    cycle(1, 0, 8'hD1); cycle(1, 0, 8'hD2);
    do_reset();
    cycle(0, 1, 8'h00);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      int bias;
      bias = (i / 100) % 2 ? 70 : 30;
      cycle($urandom_range(99, 0) < bias, $urandom_range(99, 0) >= bias,
            8'($urandom));
    end
    cycle(0, 0, 8'h00);
    @(posedge clk);
    #2;
    check("scoreboard drained", exp_q.size(), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous single-clock FIFO built around the team's existing `ram` block, which has a registered read and no reset.
- Owns the read and write pointers, the fill count, and the status flags.
- Drives the RAM write and read ports, and presents a SCFIFO-style interface to the surrounding logic.
- Sits directly upstream of the RAM; all RAM port traffic originates here.

Parameters:
- DWIDTH, 8: data word width.
- AWIDTH, 4: RAM address width; depth = 2**AWIDTH.
- ALMOST_FULL, 12: almost_full_o asserts when usedw_o >= ALMOST_FULL.
- ALMOST_EMPTY, 2: almost_empty_o asserts when usedw_o < ALMOST_EMPTY.

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_ni  in  1  asynchronous, active-low reset.
- data_i  in  DWIDTH  write data.
- wrreq_i  in  1  write request.
- rdreq_i  in  1  read request.
- q_o  out  DWIDTH  read data.
- empty_o  out  1  FIFO empty.
- full_o  out  1  FIFO full.
- usedw_o  out  AWIDTH+1  number of stored words, 0..2**AWIDTH.
- almost_full_o  out  1  fill level at or above the ALMOST_FULL threshold.
- almost_empty_o  out  1  fill level below the ALMOST_EMPTY threshold.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - wr_ptr = rd_ptr = 0, usedw_o = 0.
  - empty_o = 1, full_o = 0, almost_empty_o = 1, almost_full_o = (ALMOST_FULL == 0).
  - q_o = 0.
  - RAM contents are not cleared.
  - Reset mid-operation discards all stored words and any read in flight.
- Accept rules, evaluated on flags registered at the start of the cycle:
  - wr_acc = wrreq_i & !full_o.
  - rd_acc = rdreq_i & !empty_o.
  - A write while full is dropped silently; usedw_o does not change.
  - A read while empty is ignored; q_o holds its value.
- RAM connection:
  - wr_en = wr_acc, wr_addr = wr_ptr, wr_data = data_i.
  - rd_en = rd_acc, rd_addr = rd_ptr.
  - Each pointer increments by 1 on its accept and wraps modulo 2**AWIDTH without special handling.
- usedw_o:
  - +1 on wr_acc only; -1 on rd_acc only.
  - Unchanged on both accepts or neither.
- Simultaneous wrreq_i and rdreq_i:
  - When full: the read is accepted, the write is dropped, usedw_o goes to 2**AWIDTH-1.
  - When empty: the write is accepted, the read is ignored, usedw_o goes to 1.
  - Otherwise both are accepted; usedw_o and the flags are unchanged.
- Flags are registered and updated in the same edge as usedw_o:
  - empty_o = (next usedw == 0).
  - full_o = (next usedw == 2**AWIDTH).
  - almost_full_o and almost_empty_o are compared against the next usedw.
- Read latency (normal mode): q_o shows the word popped by rd_acc in cycle N during cycle N+1.
  - q_o then holds until the next accepted read.
  - A flop q_vld, reset to 0 and set on the first rd_acc, gates q_o to 0 until the first read data arrives.
- Write-to-read: a word written in cycle N may be read in cycle N+1, since empty_o deasserts after edge N.
- RAM write and read never hit the same address in the same cycle when accepted, because rd_acc requires at least one stored word.

Optional Feature:
- Macro: FIFO_SHOWAHEAD_EN.
- Defined (first-word fall-through):
  - An internal prefetch stage keeps the head word on q_o whenever !empty_o; rdreq_i acknowledges and pops it.
  - A first write into an empty FIFO deasserts empty_o 2 cycles later: the write edge, then the RAM read edge.
  - Back-to-back pops give a new head every cycle while usedw_o >= 2.
  - usedw_o counts the prefetched word.
  - full_o and almost_* are unchanged from normal mode.
- Undefined: normal mode as described in Behaviour.

Decomposition:
- Shared package fifo_pkg holds:
  - function usedw_width(awidth), returning awidth+1;
  - localparam defaults for DWIDTH and AWIDTH, reused by the benches.
- No struct typedefs are needed.
- One sub-module: a `ram` instance (DWIDTH, AWIDTH). Pointers, count and flags stay in fifo_ctrl.

Test Plan:
- Basic FIFO ordering (DWIDTH=8, AWIDTH=2):
  - Stimulus: reset; write 0x11, 0x22, 0x33; read 3.
  - Required: q_o = 0x11, 0x22, 0x33 on the cycles after each rdreq; empty_o = 1 and usedw_o = 0 at the end.
- Overflow:
  - Stimulus: write 0xA0..0xA4 (5 words) into depth 4.
  - Required: full_o = 1 and usedw_o = 4; 0xA4 dropped; 4 reads return 0xA0..0xA3.
- Underflow:
  - Stimulus: rdreq_i on an empty FIFO after reset.
  - Required: q_o stays 0, usedw_o stays 0, rd_ptr unchanged; a following write and read of 0x5A returns 0x5A.
- Simultaneous read and write at the boundaries:
  - Stimulus: both requests while full, then while empty.
  - Required: full case gives usedw 4 -> 3 with the write dropped; empty case gives 0 -> 1, the read ignored and empty_o = 0.
- Pointer wrap and thresholds (ALMOST_FULL=3, ALMOST_EMPTY=1):
  - Stimulus: stream 10 words with rdreq asserted one cycle behind.
  - Required: in-order data across the pointer wrap; almost_full_o asserts exactly when usedw_o reaches 3.
- Reset mid-stream, plus FIFO_SHOWAHEAD_EN:
  - Stimulus: assert rst_ni low with usedw_o = 2.
  - Required: outputs return to reset values immediately.
  - With the macro defined, a single write of 0x77 shows q_o = 0x77 and empty_o = 0 exactly 2 cycles later, before any rdreq.
